// File: rtl/final_soc_sram_reader_if.sv
// Avalon-MM register-slave bundle between the Nios II data master and the
// SRAM reader. readdata is driven back combinationally by the slave.
interface final_soc_sram_reader_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/final_soc_sram_reader.sv
// CPU-initiated single-word reader for the board's 1M x 16 async SRAM.
// Software loads PTR, writes START, polls DONE, then reads DATA.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | strobes high, PTR/CTRL/COUNT writable, waiting for START
// ST_ACCESS | ce_n/oe_n low, sram_addr frozen, wait_cnt counting down;
//           | capture into DATA on the edge where wait_cnt is zero
module final_soc_sram_reader #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    final_soc_sram_reader_if.slave  bus,
    output logic [ADDR_W-1:0]       sram_addr,
    input  logic [DATA_W-1:0]       sram_dq,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic                    sram_ub_n,
    output logic                    sram_lb_n
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   data_q;
    logic [15:0]         count;
    logic                busy;
    logic                done;
    logic                autoinc;
    logic                strobe_n;

    logic wr_en;
    logic rd_en;
    logic wr_ptr;
    logic wr_ctrl;
    logic wr_count;
    logic rd_data;
    logic start_req;

    // Upper write-data bits have no register behind them.
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:ADDR_W];

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign rd_en     = bus.chipselect & ~bus.read_n;
    assign wr_ptr    = wr_en & (bus.address == 2'd0);
    assign wr_ctrl   = wr_en & (bus.address == 2'd1);
    assign wr_count  = wr_en & (bus.address == 2'd3);
    assign rd_data   = rd_en & (bus.address == 2'd2);
    assign start_req = wr_ctrl & bus.writedata[0];

    // Upper/lower byte enables follow output enable; this block never writes.
    assign sram_ce_n = strobe_n;
    assign sram_oe_n = strobe_n;
    assign sram_ub_n = strobe_n;
    assign sram_lb_n = strobe_n;
    assign sram_we_n = 1'b1;

    // Access FSM plus register file; later assignments give capture priority
    // over a DATA-read DONE clear, and a COUNT write priority over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            ptr       <= '0;
            data_q    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            autoinc   <= 1'b0;
            strobe_n  <= 1'b1;
            sram_addr <= '0;
        end else begin
            if (wr_ctrl)
                autoinc <= bus.writedata[1];
            if (rd_data)
                done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (wr_ptr)
                        ptr <= bus.writedata[ADDR_W-1:0];
                    if (start_req) begin
                        state     <= ST_ACCESS;
                        sram_addr <= ptr;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        wait_cnt  <= WAIT_INIT;
                        strobe_n  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_IDLE;
                        data_q   <= sram_dq;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        strobe_n <= 1'b1;
                        count    <= count + 16'd1;
                        if (autoinc)
                            ptr <= ptr + ADDR_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (wr_count)
                count <= '0;
        end
    end

    // Zero-latency read mux, unused bits zero-extended.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[ADDR_W-1:0] = ptr;
            2'd1:    bus.readdata[2:0]        = {autoinc, done, busy};
            2'd2:    bus.readdata[DATA_W-1:0] = data_q;
            default: bus.readdata[15:0]       = count;
        endcase
    end

endmodule

// File: tb/tb_final_soc_sram_reader.sv
// Scoreboard bench for final_soc_sram_reader: one instance with the default
// wait setting and one with WAIT_CYCLES=0, sharing clock and reset.
module tb_final_soc_sram_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    final_soc_sram_reader_if bus0();
    final_soc_sram_reader_if bus1();

    logic [19:0] sa [2];
    logic [15:0] dq [2];
    logic        ce [2];
    logic        oe [2];
    logic        we [2];
    logic        ub [2];
    logic        lb [2];

    final_soc_sram_reader #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus0),
        .sram_addr (sa[0]),
        .sram_dq   (dq[0]),
        .sram_ce_n (ce[0]),
        .sram_oe_n (oe[0]),
        .sram_we_n (we[0]),
        .sram_ub_n (ub[0]),
        .sram_lb_n (lb[0])
    );

    final_soc_sram_reader #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .sram_addr (sa[1]),
        .sram_dq   (dq[1]),
        .sram_ce_n (ce[1]),
        .sram_oe_n (oe[1]),
        .sram_we_n (we[1]),
        .sram_ub_n (ub[1]),
        .sram_lb_n (lb[1])
    );

    // SRAM contents: 0x00123 holds 0xBEEF, every other word is addr[15:0]^0xA5A5.
    function automatic logic [15:0] sram_word(logic [19:0] a);
        if (a == 20'h00123)
            return 16'hBEEF;
        return a[15:0] ^ 16'hA5A5;
    endfunction

    always_comb begin
        dq[0] = 16'h0000;
        dq[1] = 16'h0000;
        if (!oe[0]) dq[0] = sram_word(sa[0]);
        if (!oe[1]) dq[1] = sram_word(sa[1]);
    end

    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard queues.
    typedef struct packed {
        logic        dut;
        logic [19:0] addr;
        logic [3:0]  len;
    } acc_t;

    logic [31:0] rd_exp_q  [$];
    string       rd_name_q [$];
    acc_t        acc_q     [$];

    int          low_cnt  [2];
    logic [19:0] win_addr [2];

    task automatic drive(int d, logic cs, logic rn, logic wn, logic [1:0] a, logic [31:0] wd);
        if (d == 0) begin
            bus0.chipselect = cs; bus0.read_n = rn; bus0.write_n = wn;
            bus0.address = a; bus0.writedata = wd;
        end else begin
            bus1.chipselect = cs; bus1.read_n = rn; bus1.write_n = wn;
            bus1.address = a; bus1.writedata = wd;
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic wr(int d, logic [1:0] a, logic [31:0] v);
        drive(d, 1'b1, 1'b1, 1'b0, a, v);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic rd(int d, logic [1:0] a, logic [31:0] exp, string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(d, 1'b1, 1'b0, 1'b1, a, 32'h0);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_access(int d, logic [19:0] addr, logic [3:0] len);
        acc_t e;
        e.dut  = d[0];
        e.addr = addr;
        e.len  = len;
        acc_q.push_back(e);
    endtask

    function automatic void pop_read(int d, logic [31:0] act);
        if (rd_exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_read dut%0d: got 0x%0h, expected no read", d, act);
        end else begin
            check(rd_name_q.pop_front(), act, rd_exp_q.pop_front());
        end
    endfunction

    // Read monitor: compares readdata whenever a bus read is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.chipselect && !bus0.read_n) pop_read(0, bus0.readdata);
            if (bus1.chipselect && !bus1.read_n) pop_read(1, bus1.readdata);
        end
    end

    // Access monitor: measures each low-strobe window and its address.
    always @(negedge clk) begin
        if (reset) begin
            low_cnt[0] = 0;
            low_cnt[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!ce[d]) begin
                    check($sformatf("pins_low_dut%0d", d), {28'h0, oe[d], ub[d], lb[d], we[d]}, 32'h1);
                    if (low_cnt[d] == 0)
                        win_addr[d] = sa[d];
                    else
                        check($sformatf("addr_stable_dut%0d", d), {12'h0, sa[d]}, {12'h0, win_addr[d]});
                    low_cnt[d]++;
                end else if (low_cnt[d] != 0) begin
                    if (acc_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_access dut%0d: got addr 0x%0h len %0d, expected none",
                                 d, win_addr[d], low_cnt[d]);
                    end else begin
                        acc_t e;
                        e = acc_q.pop_front();
                        check("access_dut", d, {31'h0, e.dut});
                        check("access_addr", {12'h0, win_addr[d]}, {12'h0, e.addr});
                        check("access_len", low_cnt[d], {28'h0, e.len});
                    end
                    low_cnt[d] = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
        drive(1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus0.address = 2'(a);
            #1;
            check($sformatf("reset_readdata_%0d", a), bus0.readdata, 32'h0);
        end
        bus0.address = 2'd0;
        check("reset_pins", {27'h0, ce[0], oe[0], ub[0], lb[0], we[0]}, 32'h1F);
        check("reset_sram_addr", {12'h0, sa[0]}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        rd(0, 2'd0, 32'h0, "init_ptr");
        rd(0, 2'd1, 32'h0, "init_ctrl");
        rd(0, 2'd2, 32'h0, "init_data");
        rd(0, 2'd3, 32'h0, "init_count");

        // Single read
        wr(0, 2'd0, 32'h00123);
        expect_access(0, 20'h00123, 4'd3);
        wr(0, 2'd1, 32'h1);
        rd(0, 2'd1, 32'h1, "single_busy_c1");
        rd(0, 2'd1, 32'h1, "single_busy_c2");
        rd(0, 2'd1, 32'h1, "single_busy_c3");
        rd(0, 2'd1, 32'h2, "single_done");
        rd(0, 2'd2, 32'hBEEF, "single_data");
        rd(0, 2'd1, 32'h0, "single_done_cleared");
        rd(0, 2'd3, 32'h1, "single_count");
        rd(0, 2'd0, 32'h00123, "single_ptr_kept");

        // Auto-increment wrap
        wr(0, 2'd3, 32'h0);
        wr(0, 2'd0, 32'hFFFFF);
        wr(0, 2'd1, 32'h2);
        rd(0, 2'd1, 32'h4, "autoinc_set");
        expect_access(0, 20'hFFFFF, 4'd3);
        wr(0, 2'd1, 32'h3);
        idle(4);
        rd(0, 2'd2, 32'h5A5A, "wrap_data_1");
        rd(0, 2'd0, 32'h00000, "wrap_ptr_1");
        expect_access(0, 20'h00000, 4'd3);
        wr(0, 2'd1, 32'h3);
        idle(4);
        rd(0, 2'd2, 32'hA5A5, "wrap_data_2");
        rd(0, 2'd0, 32'h00001, "wrap_ptr_2");
        rd(0, 2'd3, 32'h2, "wrap_count");

        // Busy protection
        wr(0, 2'd3, 32'h0);
        expect_access(0, 20'h00001, 4'd3);
        wr(0, 2'd1, 32'h3);
        wr(0, 2'd0, 32'h55555);
        wr(0, 2'd1, 32'h3);
        idle(4);
        rd(0, 2'd0, 32'h00002, "busy_ptr");
        rd(0, 2'd3, 32'h1, "busy_count");
        rd(0, 2'd2, 32'hA5A4, "busy_data");
        wr(0, 2'd1, 32'h0);

        // DATA read on the capture edge
        wr(0, 2'd0, 32'h00010);
        expect_access(0, 20'h00010, 4'd3);
        wr(0, 2'd1, 32'h1);
        idle(2);
        rd(0, 2'd2, 32'hA5A4, "coll_data_old");
        rd(0, 2'd1, 32'h2, "coll_done_set_wins");
        rd(0, 2'd2, 32'hA5B5, "coll_data_new");
        rd(0, 2'd1, 32'h0, "coll_done_cleared");

        // COUNT write on the capture edge
        expect_access(0, 20'h00010, 4'd3);
        wr(0, 2'd1, 32'h1);
        idle(2);
        wr(0, 2'd3, 32'h1234);
        rd(0, 2'd3, 32'h0, "coll_count_clear_wins");
        rd(0, 2'd1, 32'h2, "coll_count_done");
        rd(0, 2'd2, 32'hA5B5, "coll_count_data");

        // Reset mid-access
        wr(0, 2'd1, 32'h2);
        wr(0, 2'd0, 32'h00077);
        wr(0, 2'd1, 32'h3);
        idle(1);
        check("midacc_strobe_low", {31'h0, ce[0]}, 32'h0);
        reset = 1'b1;
        #1;
        check("midacc_pins", {27'h0, ce[0], oe[0], ub[0], lb[0], we[0]}, 32'h1F);
        check("midacc_sram_addr", {12'h0, sa[0]}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus0.address = 2'(a);
            #1;
            check($sformatf("midacc_readdata_%0d", a), bus0.readdata, 32'h0);
        end
        bus0.address = 2'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        rd(0, 2'd1, 32'h0, "post_reset_ctrl");
        rd(0, 2'd0, 32'h0, "post_reset_ptr");

        // WAIT_CYCLES=0 build
        wr(1, 2'd0, 32'h00200);
        expect_access(1, 20'h00200, 4'd1);
        wr(1, 2'd1, 32'h1);
        rd(1, 2'd1, 32'h1, "w0_busy");
        rd(1, 2'd1, 32'h2, "w0_done");
        rd(1, 2'd2, 32'hA7A5, "w0_data");
        rd(1, 2'd3, 32'h1, "w0_count");

        idle(3);
        check("read_queue_empty", 32'(rd_exp_q.size()), 32'h0);
        check("access_queue_empty", 32'(acc_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
